// File: rtl/alu_bist.sv
// Self-test driver for the 4-bit ALU: walks every opcode with LFSR operands and
// folds the ALU responses into a 16-bit MISR that is compared against a golden value.
module alu_bist #(
  parameter int          VECS_PER_OP = 16,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter logic [15:0] SIG_INIT    = 16'hFFFF,
  parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  ALU_cont,
  output logic        Cin,
  input  logic [3:0]  X,
  input  logic        Cout,
  input  logic        Zero,
  input  logic        Overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  localparam int N  = 16 * VECS_PER_OP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    sig_q, sig_d;
  logic [3:0]     a_q, a_d, b_q, b_d, op_q, op_d;
  logic           cin_q, cin_d, pass_q, pass_d;

  logic           launch, issue, capture;
  logic [7:0]     vec;
  logic [CW-1:0]  idx;
  logic [15:0]    sig_step;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_RUN;
        launch  = 1'b1;
      end
      S_RUN:   if (cnt_q == CW'(N - 1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  // Datapath: cnt_q holds the index of the next vector to issue
  always_comb begin
    issue    = launch || (state_q == S_RUN);
    capture  = (state_q == S_RUN) || (state_q == S_DRAIN);
    vec      = launch ? SEED : lfsr_q;
    idx      = launch ? '0 : cnt_q;
    sig_step = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
             ^ {9'b0, Overflow, Zero, Cout, X};

    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cin_d  = cin_q;
    sig_d  = sig_q;
    pass_d = pass_q;

    if (issue) begin
      a_d    = vec[7:4];
      b_d    = vec[3:0];
      cin_d  = vec[7] ^ vec[0];
      op_d   = 4'(idx / CW'(VECS_PER_OP));
      lfsr_d = {vec[6:0], vec[7] ^ vec[5] ^ vec[4] ^ vec[3]};
      cnt_d  = idx + CW'(1);
    end

    if (launch) begin
      sig_d  = SIG_INIT;
      pass_d = 1'b0;
    end else if (capture) begin
      sig_d = sig_step;
      // Last capture happens on the DRAIN edge; judge the post-capture value
      if (state_q == S_DRAIN) pass_d = (sig_step == GOLDEN_SIG);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cin_q  <= 1'b0;
      sig_q  <= SIG_INIT;
      pass_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cin_q  <= cin_d;
      sig_q  <= sig_d;
      pass_q <= pass_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_cont  = op_q;
  assign Cin       = cin_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: behavioural 4-bit ALU in the loop, plus an
// independent LFSR/MISR model that predicts every vector and signature.
module tb_alu_bist;
  localparam int          VPO    = 16;
  localparam int          NV     = 16 * VPO;
  localparam logic [7:0]  SEED_T = 8'hA5;

  function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op, input logic cin);
    logic [4:0] r;
    logic       ov;
    r  = 5'd0;
    ov = 1'b0;
    case (op)
      4'd0:  begin
        r  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        ov = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'd1:  begin
        r  = {1'b0, a} + {1'b0, ~b} + 5'd1;
        ov = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'd2:  r = {1'b0, a & b};
      4'd3:  r = {1'b0, a | b};
      4'd4:  r = {1'b0, a ^ b};
      4'd5:  r = {1'b0, ~a};
      4'd6:  r = {a, 1'b0};
      4'd7:  r = {1'b0, 1'b0, a[3:1]};
      4'd8:  r = {1'b0, a} + 5'd1;
      4'd9:  r = {1'b0, b};
      4'd10: r = {1'b0, ~(a & b)};
      4'd11: r = {1'b0, ~(a | b)};
      4'd12: r = {1'b0, ~(a ^ b)};
      4'd13: r = {1'b0, a} + {1'b0, b};
      4'd14: r = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
      default: r = 5'd0;
    endcase
    return {ov, r[3:0] == 4'd0, r[4], r[3:0]};
  endfunction

  function automatic logic [7:0] lfsr_f(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] misr_f(input logic [15:0] s, input logic [6:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'b0, d};
  endfunction

  function automatic logic [15:0] calc_golden();
    logic [7:0]  l;
    logic [15:0] s;
    l = SEED_T;
    s = 16'hFFFF;
    for (int j = 0; j < NV; j++) begin
      s = misr_f(s, alu_f(l[7:4], l[3:0], 4'(j / VPO), l[7] ^ l[0]));
      l = lfsr_f(l);
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD = calc_golden();

  logic        clk, rst_n, start;
  logic [3:0]  A, B, ALU_cont, X;
  logic        Cin, Cout, Zero, Overflow, busy, done, pass;
  logic [15:0] signature;
  logic        stub, corrupt;
  int          checks, failures;

  alu_bist #(.VECS_PER_OP(VPO), .SEED(SEED_T), .SIG_INIT(16'hFFFF), .GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B), .ALU_cont(ALU_cont), .Cin(Cin),
    .X(X), .Cout(Cout), .Zero(Zero), .Overflow(Overflow),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  // ALU under test (or an all-zero stub), with an optional X[0] flip
  always_comb begin
    logic [6:0] r;
    r = stub ? 7'd0 : alu_f(A, B, ALU_cont, Cin);
    X        = r[3:0] ^ {3'b0, corrupt};
    Cout     = r[4];
    Zero     = r[5];
    Overflow = r[6];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {A,B,Cin,ALU_cont,busy,done}
  function automatic logic [31:0] pack_out();
    return {17'b0, A, B, Cin, ALU_cont, busy, done};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [7:0] l, input int j,
                                           input logic bz, input logic dn);
    return {17'b0, l[7:4], l[3:0], l[7] ^ l[0], 4'(j / VPO), bz, dn};
  endfunction

  // One full run from a start pulse; cidx selects a vector whose X[0] is flipped
  task automatic run_test(input string name, input bit hold, input int cidx);
    logic [7:0]  l, last_l;
    logic [15:0] s;
    logic [6:0]  d;
    l = SEED_T;
    s = 16'hFFFF;
    last_l = l;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int j = 0; j < NV; j++) begin
      check({name, "_vec"}, pack_out(), pack_exp(l, j, 1'b1, 1'b0));
      check({name, "_sig"}, {16'b0, signature}, {16'b0, s});
      corrupt = (j == cidx);
      d = stub ? 7'd0 : alu_f(l[7:4], l[3:0], 4'(j / VPO), l[7] ^ l[0]);
      if (j == cidx) d[0] = ~d[0];
      s = misr_f(s, d);
      last_l = l;
      l = lfsr_f(l);
      tick();
    end
    corrupt = 1'b0;
    check({name, "_done_vec"}, pack_out(), pack_exp(last_l, NV - 1, 1'b0, 1'b1));
    check({name, "_final_sig"}, {16'b0, signature}, {16'b0, s});
    check({name, "_pass"}, {31'b0, pass}, {31'b0, s == GOLD});
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    stub = 1'b0;
    corrupt = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_out", pack_out(), 32'd0);
    check("reset_pass", {31'b0, pass}, 32'd0);
    check("reset_sig", {16'b0, signature}, 32'h0000FFFF);
    rst_n = 1'b1;
    tick();
    check("idle_hold", pack_out(), 32'd0);

    run_test("good", 1'b0, -1);
    check("good_pass_set", {31'b0, pass}, 32'd1);
    tick();
    check("done_held", {30'b0, busy, done}, 32'd1);

    run_test("corrupt", 1'b0, 37);
    check("corrupt_pass_clr", {31'b0, pass}, 32'd0);

    stub = 1'b1;
    run_test("stub", 1'b0, -1);
    stub = 1'b0;

    run_test("hold_start", 1'b1, -1);

    // Abort a run at vector 100 with reset
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 100; j++) tick();
    check("mid_busy", {30'b0, busy, done}, 32'd2);
    rst_n = 1'b0;
    tick();
    check("mid_reset_out", pack_out(), 32'd0);
    check("mid_reset_pass", {31'b0, pass}, 32'd0);
    check("mid_reset_sig", {16'b0, signature}, 32'h0000FFFF);
    tick();
    rst_n = 1'b1;
    tick();
    run_test("after_reset", 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
